// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: controller state encoding,
// ALU op codes and default sizing.
package alu_pkg;

    localparam int ALU_WIDTH_DEF   = 8;
    localparam int ALU_TIMEOUT_DEF = 31;
    localparam int WD_BITS         = 8;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational winner selection with a registered
// priority pointer that moves away from the requester just served.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic served,
    output logic any_req,
    output logic winner
);

    logic ptr_q;
    logic ptr_d;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = ptr_q;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

    // Next pointer: hand priority to the other requester after each service.
    always_comb begin
        if (upd) begin
            ptr_d = ~served;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one multi-cycle ALU between two requesters: arbitrates, captures operands,
// issues a start pulse, waits for finish under a watchdog and returns the result.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH_DEF,
    parameter int TIMEOUT = ALU_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [1:0]           op0,
    input  logic [1:0]           op1,
    input  logic [WIDTH-1:0]     x0,
    input  logic [WIDTH-1:0]     y0,
    input  logic [WIDTH-1:0]     x1,
    input  logic [WIDTH-1:0]     y1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 alu_start,
    output logic [1:0]           alu_s,
    output logic [WIDTH-1:0]     alu_x,
    output logic [WIDTH-1:0]     alu_y,
    input  logic                 alu_finish,
    input  logic [2*WIDTH-1:0]   alu_result
);

    localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT);

    state_t               state_q, state_d;
    logic                 win_q, win_d;
    logic [WD_BITS-1:0]   wd_q, wd_d;
    logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                 done0_q, done0_d, done1_q, done1_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 err_q, err_d;
    logic                 alu_start_q, alu_start_d;
    logic [1:0]           alu_s_q, alu_s_d;
    logic [WIDTH-1:0]     alu_x_q, alu_x_d, alu_y_q, alu_y_d;
    logic                 arb_any_s, arb_win_s, arb_upd_s;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .upd     (arb_upd_s),
        .served  (win_q),
        .any_req (arb_any_s),
        .winner  (arb_win_s)
    );

    // Sequencing: next state, watchdog, capture registers and output pulses.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        wd_d        = wd_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        alu_start_d = 1'b0;
        alu_s_d     = alu_s_q;
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        result_d    = result_q;
        err_d       = err_q;
        arb_upd_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    win_d       = arb_win_s;
                    alu_s_d     = arb_win_s ? op1 : op0;
                    alu_x_d     = arb_win_s ? x1 : x0;
                    alu_y_d     = arb_win_s ? y1 : y0;
                    gnt0_d      = ~arb_win_s;
                    gnt1_d      = arb_win_s;
                    alu_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wd_d    = {WD_BITS{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A finish on the terminal watchdog cycle still counts as success.
                if (alu_finish) begin
                    result_d = alu_result;
                    err_d    = 1'b0;
                    done0_d  = ~win_q;
                    done1_d  = win_q;
                    state_d  = ST_DONE;
                end else if (wd_q == WD_LIMIT) begin
                    result_d = {(2*WIDTH){1'b0}};
                    err_d    = 1'b1;
                    done0_d  = ~win_q;
                    done1_d  = win_q;
                    state_d  = ST_DONE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            ST_DONE: begin
                arb_upd_s = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= 1'b0;
            wd_q        <= {WD_BITS{1'b0}};
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            alu_start_q <= 1'b0;
            alu_s_q     <= 2'b00;
            alu_x_q     <= {WIDTH{1'b0}};
            alu_y_q     <= {WIDTH{1'b0}};
            result_q    <= {(2*WIDTH){1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            wd_q        <= wd_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            alu_start_q <= alu_start_d;
            alu_s_q     <= alu_s_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign result    = result_q;
    assign err       = err_q;
    assign alu_start = alu_start_q;
    assign alu_s     = alu_s_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus random traffic, checked every
// cycle against a transaction-timeline reference model.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int RW = 2 * W;
    localparam int TO = 31;

    logic clk = 1'b0;
    logic rst;
    logic req0, req1;
    logic [1:0] op0, op1;
    logic [W-1:0] x0, y0, x1, y1;
    logic gnt0, gnt1, done0, done1, err, alu_start, alu_finish;
    logic [RW-1:0] result, alu_result;
    logic [1:0] alu_s;
    logic [W-1:0] alu_x, alu_y;

    alu_share_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .result(result), .err(err),
        .alu_start(alu_start), .alu_s(alu_s), .alu_x(alu_x), .alu_y(alu_y),
        .alu_finish(alu_finish), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: each accepted request becomes a timeline of absolute cycles.
    bit busy, win, ptr_m;
    int idle_from, gnt_c, wait_c, fin_c, end_c, done_c;
    logic [1:0]    e_s;
    logic [W-1:0]  e_x, e_y;
    logic [RW-1:0] e_res, p_res, force_res;
    bit e_err, p_err, force_res_en;
    int force_lat = -1;
    int stray_pct = 10;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 6);
        else if (r == 6) return TO;
        else if (r == 7) return TO - 1;
        else return TO + 1;
    endfunction

    // Decide what the controller must do because of this cycle's inputs.
    task automatic model_update();
        int lat;
        if (rst) begin
            busy = 1'b0; ptr_m = 1'b0; idle_from = cyc + 1;
            e_s = '0; e_x = '0; e_y = '0; e_res = '0; e_err = 1'b0;
        end else if (!busy && cyc >= idle_from && (req0 || req1)) begin
            win    = (req0 && req1) ? ptr_m : req1;
            busy   = 1'b1;
            gnt_c  = cyc + 1;
            wait_c = cyc + 2;
            lat    = (force_lat >= 0) ? force_lat : pick_lat();
            if (lat <= TO) begin
                fin_c = wait_c + lat; end_c = fin_c; p_err = 1'b0;
            end else begin
                fin_c = -1; end_c = wait_c + TO; p_res = '0; p_err = 1'b1;
            end
            done_c    = end_c + 1;
            idle_from = done_c + 1;
            ptr_m     = !win;
            e_s = win ? op1 : op0;
            e_x = win ? x1 : x0;
            e_y = win ? y1 : y0;
        end
    endtask

    task automatic step();
        bit in_wait;
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        if (busy && cyc == done_c) begin
            e_res = p_res; e_err = p_err;
        end
        chk("gnt0",      32'(gnt0),      32'(busy && cyc == gnt_c && !win));
        chk("gnt1",      32'(gnt1),      32'(busy && cyc == gnt_c && win));
        chk("alu_start", 32'(alu_start), 32'(busy && cyc == gnt_c));
        chk("done0",     32'(done0),     32'(busy && cyc == done_c && !win));
        chk("done1",     32'(done1),     32'(busy && cyc == done_c && win));
        chk("alu_s",     32'(alu_s),     32'(e_s));
        chk("alu_x",     32'(alu_x),     32'(e_x));
        chk("alu_y",     32'(alu_y),     32'(e_y));
        chk("result",    32'(result),    32'(e_res));
        chk("err",       32'(err),       32'(e_err));
        if (busy && cyc == done_c) busy = 1'b0;
        // ALU model: finish only at the planned cycle inside WAIT, strays elsewhere.
        in_wait    = busy && cyc >= wait_c && cyc <= end_c;
        alu_result = RW'($urandom);
        if (in_wait) alu_finish = (cyc == fin_c);
        else alu_finish = ($urandom_range(0, 99) < stray_pct);
        if (in_wait && cyc == fin_c) begin
            if (force_res_en) alu_result = force_res;
            p_res = alu_result;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic serve(input int who, input logic [1:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int lat);
        int k;
        k = 0;
        force_lat = lat;
        if (who == 0) begin req0 = 1'b1; op0 = op; x0 = x; y0 = y; end
        else begin req1 = 1'b1; op1 = op; x1 = x; y1 = y; end
        do begin
            step();
            k++;
        end while (!(who == 0 ? gnt0 : gnt1) && k < 100);
        chk("gnt_seen", 32'(who == 0 ? gnt0 : gnt1), 32'd1);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic rand_reqs();
        if (gnt0 && $urandom_range(0, 1) == 1) req0 = 1'b0;
        if (gnt1 && $urandom_range(0, 1) == 1) req1 = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            if (!req0) begin op0 = 2'($urandom); x0 = W'($urandom); y0 = W'($urandom); end
            req0 = ($urandom_range(0, 9) < 6);
        end
        if ($urandom_range(0, 3) == 0) begin
            if (!req1) begin op1 = 2'($urandom); x1 = W'($urandom); y1 = W'($urandom); end
            req1 = ($urandom_range(0, 9) < 6);
        end
        rst = ($urandom_range(0, 499) == 0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; alu_finish = 1'b0; alu_result = '0;
        busy = 1'b0; win = 1'b0; ptr_m = 1'b0; idle_from = 0;
        gnt_c = -1; wait_c = -1; fin_c = -1; end_c = -1; done_c = -1;
        e_s = '0; e_x = '0; e_y = '0; e_res = '0; p_res = '0; e_err = 1'b0; p_err = 1'b0;
        force_res_en = 1'b0; force_res = '0;

        run(2);
        rst = 1'b0;

        // Single multiply: ALU finishes 9 cycles after start with 16'hFFEB.
        force_res_en = 1'b1; force_res = 16'hFFEB;
        serve(0, OP_MUL, 8'd7, 8'hFD, 8);
        run(12);
        force_res_en = 1'b0;

        // Reset in the middle of WAIT, then a lone req1 is served.
        serve(0, OP_ADD, 8'h5A, 8'hC3, TO + 1);
        run(4);
        rst = 1'b1; step(); rst = 1'b0;
        serve(1, OP_SUB, 8'h11, 8'h22, 2);
        run(6);

        // Contention from reset: alternating grants starting with requester 0.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        op0 = OP_DIV; x0 = 8'h90; y0 = 8'h07; op1 = OP_ADD; x1 = 8'h01; y1 = 8'hFF;
        force_lat = 3;
        step(); rst = 1'b0;
        run(60);
        req0 = 1'b0; req1 = 1'b0;
        run(6);

        // Withdrawn req1 pulse while busy; only requester 0 is served.
        serve(0, OP_SUB, 8'h33, 8'h44, 6);
        run(3);
        req1 = 1'b1; step(); req1 = 1'b0;
        run(10);
        serve(0, OP_ADD, 8'h80, 8'h80, 2);
        run(6);

        // Timeout on requester 0; pointer must still hand priority to requester 1.
        serve(0, OP_MUL, 8'hFF, 8'hFF, TO + 1);
        req0 = 1'b1; req1 = 1'b1; force_lat = 2;
        run(TO + 15);
        req0 = 1'b0; req1 = 1'b0;
        run(6);

        // Finish on the terminal watchdog cycle.
        serve(1, OP_DIV, 8'h64, 8'h05, TO);
        run(TO + 6);

        // Stray finish pulses while idle.
        stray_pct = 60;
        run(12);
        stray_pct = 10;

        // Random traffic.
        force_lat = -1;
        for (int i = 0; i < 2500; i++) begin
            rand_reqs();
            step();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        run(45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing arbiter that shares the single ALU (add/sub/Booth multiply/divide, start/finish handshake) between two requesters. It performs round-robin arbitration, captures the winner's operands and op select, pulses ALU start, and waits for ALU finish under a watchdog. It then returns the result and completion pulse to the winner. It sits between the requester logic and the ALU's control unit and datapath.

## Interface
- WIDTH, 8, operand width; result is 2*WIDTH
- TIMEOUT, 31, maximum WAIT cycles before abort (1..255)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1  request from requester 0 / 1
- op0, op1  in  2  op select, passed to ALU s unchanged
- x0, y0, x1, y1  in  WIDTH  operands per requester
- gnt0, gnt1  out  1  one-cycle grant pulse; operands have been captured
- done0, done1  out  1  one-cycle completion pulse to the served requester
- result  out  2*WIDTH  result of the last served op; valid with done
- err  out  1  high with done when the op timed out
- alu_start  out  1  one-cycle start pulse to the ALU
- alu_s  out  2  registered op select
- alu_x, alu_y  out  WIDTH  registered operands
- alu_finish  in  1  ALU completion
- alu_result  in  2*WIDTH  ALU result, valid while alu_finish is high

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, no req: stay.
- IDLE, any req: pick the winner. Capture its op/x/y into alu_s/alu_x/alu_y at the clock edge. Go to ISSUE.
- ISSUE, one cycle: gnt_w=1, alu_start=1, watchdog cleared. Go to WAIT.
- WAIT:
  - alu_finish=1: capture alu_result into result, err=0, go to DONE.
  - Otherwise, when the watchdog reaches TIMEOUT: result=0, err=1, go to DONE.
  - Otherwise: increment the watchdog.
  - alu_finish and the terminal count in the same cycle: finish wins.
- DONE, one cycle: done_w=1. Move the priority pointer to the other requester. Go to IDLE.
- Arbitration: a single requester wins regardless of the pointer. With both requesting, the pointer picks the winner. Pointer resets to 0.
- Requester rules:
  - Hold req with stable op/x/y until gnt.
  - Dropping req before gnt withdraws the request.
  - After gnt, req is ignored. The op completes and done still pulses, even if req has dropped.
- alu_finish outside WAIT is ignored.
- result and err hold their value until the next DONE.
- Reset, including mid-operation:
  - State returns to IDLE and the pointer to 0.
  - All outputs go to 0: gnt, done, alu_start, alu_s/x/y, result, err.
  - The ALU shares rst, so no abort handshake is needed.

## Timing
- All outputs are registered.
- Request seen in IDLE at cycle N:
  - gnt and alu_start high in cycle N+1.
  - WAIT starts in cycle N+2.
- alu_finish sampled in WAIT at cycle M: done/result/err valid in cycle M+1. IDLE at M+2.
- Minimum service time, request to done: 3 cycles plus ALU latency.
- Next grant is at the earliest 2 cycles after done.
- Timeout: err/done appear TIMEOUT+1 cycles after the WAIT entry cycle.
- Watchdog width: 8 bits.

## Structure
- Package alu_pkg:
  - State encoding localparams.
  - Op codes (00 add, 01 sub, 10 mul, 11 div), used only by the bench.
  - Default WIDTH and TIMEOUT.
- Sub-module rr_arbiter2:
  - Combinational winner from req0/req1 and the pointer.
  - The registered pointer advances on an update strobe driven in DONE.
- The FSM, watchdog and capture registers live in the top.

## Test plan
- Reset mid-WAIT, asserted in WAIT with alu_finish low → next cycle IDLE, all outputs 0, pointer 0. A following req1 is granted normally.
- Single op: req0, op=10, x0=8'd7, y0=8'hFD. ALU model finishes after 9 cycles with 16'hFFEB. Required response:
  - gnt0 in cycle N+1, alu_start 1 cycle.
  - done0 one cycle after finish, result=16'hFFEB, err=0.
- Contention: req0 and req1 both held from reset.
  - Grants are gnt0, then gnt1, then gnt0, alternating.
  - No grant while an op is in flight.
- Withdraw: req1 pulsed 0 cycles before arbitration; req0 requests later → only gnt0, no done1.
- Timeout, with the ALU model never finishing:
  - done0 with err=1 and result=0 exactly TIMEOUT+1 cycles after WAIT entry.
  - The pointer still advances.
- Finish on the terminal timeout cycle → err=0, result=alu_result. Stray alu_finish in IDLE → no done.
